// File: rtl/usb_ctl_mux_if.sv
// usb_ctl_mux_if: control-port bundle between usb_xfer, the control
// router and its request handlers. The slave view belongs to usb_ctl_mux.
// The master view belongs to whatever drives usb_xfer and the handlers.
interface usb_ctl_mux_if #(
  parameter int NUM_HANDLERS = 2,
  parameter int OWNER_BITS   = 3
);
  // usb_xfer side
  logic                      xfer_req_i;
  logic                      xfer_gnt_o;
  logic                      xfer_done_o;
  logic                      xfer_stall_o;
  logic                      xfer_dvalid_i;
  logic                      xfer_tvalid_o;
  logic                      xfer_tlast_o;
  logic                      xfer_tready_i;
  logic [7:0]                xfer_tdata_o;
  // handler side
  logic [NUM_HANDLERS-1:0]   hnd_claim_i;
  logic [NUM_HANDLERS-1:0]   hnd_req_o;
  logic [NUM_HANDLERS-1:0]   hnd_gnt_i;
  logic [NUM_HANDLERS-1:0]   hnd_done_i;
  logic [NUM_HANDLERS-1:0]   hnd_dvalid_o;
  logic [NUM_HANDLERS-1:0]   hnd_tvalid_i;
  logic [NUM_HANDLERS-1:0]   hnd_tlast_i;
  logic [NUM_HANDLERS-1:0]   hnd_tready_o;
  logic [8*NUM_HANDLERS-1:0] hnd_tdata_i;
  // status
  logic [OWNER_BITS-1:0]     owner_o;
  logic                      busy_o;

  modport slave (
    input  xfer_req_i, xfer_dvalid_i, xfer_tready_i,
           hnd_claim_i, hnd_gnt_i, hnd_done_i, hnd_tvalid_i, hnd_tlast_i, hnd_tdata_i,
    output xfer_gnt_o, xfer_done_o, xfer_stall_o, xfer_tvalid_o, xfer_tlast_o, xfer_tdata_o,
           hnd_req_o, hnd_dvalid_o, hnd_tready_o, owner_o, busy_o
  );

  modport master (
    output xfer_req_i, xfer_dvalid_i, xfer_tready_i,
           hnd_claim_i, hnd_gnt_i, hnd_done_i, hnd_tvalid_i, hnd_tlast_i, hnd_tdata_i,
    input  xfer_gnt_o, xfer_done_o, xfer_stall_o, xfer_tvalid_o, xfer_tlast_o, xfer_tdata_o,
           hnd_req_o, hnd_dvalid_o, hnd_tready_o, owner_o, busy_o
  );
endinterface

// File: rtl/usb_ctl_mux.sv
// usb_ctl_mux: claim-based N-way router for USB control transfers.
// A pending transfer opens a claim window of CLAIM_CYCLES cycles. The lowest
// claiming handler is latched as owner and gets the whole control port until
// usb_xfer withdraws the request. If no handler claims, the transfer is
// STALLed.
// Optional feature: define USB_CTL_MUX_SKID_EN to place a 2-entry skid buffer
// on the muxed IN stream (registered xfer_t* outputs, +1 cycle latency).
module usb_ctl_mux #(
  parameter int NUM_HANDLERS = 2,
  parameter int OWNER_BITS   = 3,
  parameter int CLAIM_CYCLES = 4
) (
  input  logic         clock,
  input  logic         reset,
  usb_ctl_mux_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CLAIM, S_OWNED, S_STALL} state_t;

  state_t                  state;
  logic [OWNER_BITS-1:0]   owner;
  logic [7:0]              claim_cnt;
  logic [OWNER_BITS-1:0]   claim_idx;
  logic                    claim_any;
  logic [NUM_HANDLERS-1:0] owner_oh;
  logic                    sel_tvalid;
  logic                    sel_tlast;
  logic [7:0]              sel_tdata;

  assign claim_any = |bus.hnd_claim_i;

  // Priority-encode the claim vector; the lowest index wins.
  always_comb begin
    // NOTE: a default before any conditional assignment keeps this combinational (no latch).
    claim_idx = '0;
    for (int k = NUM_HANDLERS - 1; k >= 0; k--) begin
      if (bus.hnd_claim_i[k]) claim_idx = OWNER_BITS'(k);
    end
  end

  // Arbitration FSM: claim window, latched owner, stall, and abort on request drop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= '0;
      claim_cnt <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      case (state)
        S_IDLE: begin
          if (bus.xfer_req_i) begin
            state     <= S_CLAIM;
            claim_cnt <= '0;
          end
        end
        S_CLAIM: begin
          if (!bus.xfer_req_i) begin
            state <= S_IDLE;
          end else if (claim_any) begin
            state <= S_OWNED;
            owner <= claim_idx;
          end else if (claim_cnt == 8'(CLAIM_CYCLES - 1)) begin
            state <= S_STALL;
          end else begin
            claim_cnt <= claim_cnt + 8'd1;
          end
        end
        S_OWNED: begin
          if (!bus.xfer_req_i) state <= S_IDLE;
        end
        S_STALL: begin
          if (!bus.xfer_req_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Owner one-hot and the owner's IN stream selection.
  always_comb begin
    owner_oh   = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tdata  = 8'h00;
    for (int k = 0; k < NUM_HANDLERS; k++) begin
      if (state == S_OWNED && owner == OWNER_BITS'(k)) begin
        owner_oh[k] = 1'b1;
        sel_tvalid  = bus.hnd_tvalid_i[k];
        sel_tlast   = bus.hnd_tlast_i[k];
        sel_tdata   = bus.hnd_tdata_i[8*k +: 8];
      end
    end
  end

  assign bus.hnd_req_o    = owner_oh;
  assign bus.xfer_gnt_o   = |(bus.hnd_gnt_i & owner_oh);
  assign bus.xfer_done_o  = |(bus.hnd_done_i & owner_oh);
  assign bus.hnd_dvalid_o = owner_oh & {NUM_HANDLERS{bus.xfer_dvalid_i}};
  assign bus.xfer_stall_o = (state == S_STALL);
  assign bus.owner_o      = owner;
  assign bus.busy_o       = (state != S_IDLE);

`ifdef USB_CTL_MUX_SKID_EN
  logic       head_v, tail_v;
  logic [8:0] head_d, tail_d;
  logic       push, pop, flush;

  assign flush = (state != S_OWNED) || !bus.xfer_req_i;
  assign push  = (state == S_OWNED) && sel_tvalid && !tail_v;
  assign pop   = head_v && bus.xfer_tready_i;

  // Two-entry skid buffer: head feeds usb_xfer, tail absorbs one extra byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the data slots are reset too because they drive outputs that must read 0.
      head_v <= 1'b0;
      tail_v <= 1'b0;
      head_d <= '0;
      tail_d <= '0;
    end else if (flush) begin
      head_v <= 1'b0;
      tail_v <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!head_v) begin
            head_v <= 1'b1;
            head_d <= {sel_tlast, sel_tdata};
          end else begin
            tail_v <= 1'b1;
            tail_d <= {sel_tlast, sel_tdata};
          end
        end
        2'b01: begin
          head_v <= tail_v;
          head_d <= tail_d;
          tail_v <= 1'b0;
        end
        2'b11: head_d <= {sel_tlast, sel_tdata};
        default: ;
      endcase
    end
  end

  assign bus.xfer_tvalid_o = head_v;
  assign bus.xfer_tlast_o  = head_d[8];
  assign bus.xfer_tdata_o  = head_d[7:0];
  assign bus.hnd_tready_o  = owner_oh & {NUM_HANDLERS{!tail_v}};
`else
  assign bus.xfer_tvalid_o = sel_tvalid;
  assign bus.xfer_tlast_o  = sel_tlast;
  assign bus.xfer_tdata_o  = sel_tdata;
  assign bus.hnd_tready_o  = owner_oh & {NUM_HANDLERS{bus.xfer_tready_i}};
`endif

endmodule

// File: tb/tb_usb_ctl_mux.sv
// tb_usb_ctl_mux: directed scenarios plus randomized traffic for usb_ctl_mux,
// checked every cycle against a transaction-level reference model.
module tb_usb_ctl_mux;
  localparam int N  = 3;
  localparam int OB = 3;
  localparam int CC = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  usb_ctl_mux_if #(.NUM_HANDLERS(N), .OWNER_BITS(OB)) bus ();
  usb_ctl_mux #(.NUM_HANDLERS(N), .OWNER_BITS(OB), .CLAIM_CYCLES(CC)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  // Second instance for the single-cycle claim window corner.
  usb_ctl_mux_if #(.NUM_HANDLERS(2), .OWNER_BITS(1)) bus1 ();
  usb_ctl_mux #(.NUM_HANDLERS(2), .OWNER_BITS(1), .CLAIM_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the transfer, whether we are waiting for a claim,
  // how long we have waited, and whether the transfer was refused.
  int m_owner      = -1;
  int m_last_owner = 0;
  bit m_wait       = 1'b0;
  bit m_stall      = 1'b0;
  int m_waited     = 0;

  function automatic int lowest_set(input logic [N-1:0] v);
    int iso;
    iso = int'(v) & -int'(v);
    return $clog2(iso);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_owner <= -1; m_last_owner <= 0; m_wait <= 1'b0; m_stall <= 1'b0; m_waited <= 0;
    end else if (!bus.xfer_req_i) begin
      m_owner <= -1; m_wait <= 1'b0; m_stall <= 1'b0;
    end else if (m_owner < 0 && !m_wait && !m_stall) begin
      m_wait <= 1'b1; m_waited <= 0;
    end else if (m_wait) begin
      if (bus.hnd_claim_i != '0) begin
        m_owner      <= lowest_set(bus.hnd_claim_i);
        m_last_owner <= lowest_set(bus.hnd_claim_i);
        m_wait       <= 1'b0;
      end else begin
        m_waited <= m_waited + 1;
        if (m_waited + 1 == CC) begin
          m_stall <= 1'b1;
          m_wait  <= 1'b0;
        end
      end
    end
  end

  task automatic compare_outputs();
    logic [N-1:0] oh;
    int o;
    o  = m_owner;
    oh = '0;
    if (o >= 0) oh[o] = 1'b1;
    check("hnd_req",     32'(bus.hnd_req_o), 32'(oh));
    check("xfer_gnt",    32'(bus.xfer_gnt_o), (o >= 0) ? 32'(bus.hnd_gnt_i[o]) : 32'd0);
    check("xfer_done",   32'(bus.xfer_done_o), (o >= 0) ? 32'(bus.hnd_done_i[o]) : 32'd0);
    check("xfer_stall",  32'(bus.xfer_stall_o), 32'(m_stall));
    check("hnd_dvalid",  32'(bus.hnd_dvalid_o), bus.xfer_dvalid_i ? 32'(oh) : 32'd0);
    check("hnd_tready",  32'(bus.hnd_tready_o), bus.xfer_tready_i ? 32'(oh) : 32'd0);
    check("xfer_tvalid", 32'(bus.xfer_tvalid_o), (o >= 0) ? 32'(bus.hnd_tvalid_i[o]) : 32'd0);
    check("xfer_tlast",  32'(bus.xfer_tlast_o), (o >= 0) ? 32'(bus.hnd_tlast_i[o]) : 32'd0);
    check("xfer_tdata",  32'(bus.xfer_tdata_o), (o >= 0) ? 32'(bus.hnd_tdata_i[8*o +: 8]) : 32'd0);
    check("owner",       32'(bus.owner_o), 32'(m_last_owner));
    check("busy",        32'(bus.busy_o), 32'(m_wait || m_stall || (o >= 0)));
  endtask

  // One compare per cycle, mid-low-phase, after the driver has settled inputs.
  always @(negedge clock) begin
    #2;
    compare_outputs();
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    bus.xfer_req_i = 1'b0; bus.xfer_dvalid_i = 1'b0; bus.xfer_tready_i = 1'b0;
    bus.hnd_claim_i = '0; bus.hnd_gnt_i = '0; bus.hnd_done_i = '0;
    bus.hnd_tvalid_i = '0; bus.hnd_tlast_i = '0; bus.hnd_tdata_i = '0;
  endtask

  // Establish ownership by a given claim vector starting from IDLE.
  task automatic acquire(input logic [N-1:0] claims);
    bus.xfer_req_i = 1'b1;
    bus.hnd_claim_i = claims;
    tick();
    tick();
  endtask

  logic [7:0] desc [18];
  logic [7:0] rx   [18];
  int got, last_at, bad, t2_seen, own_p, other_p;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    bus1.xfer_req_i = 1'b0; bus1.xfer_dvalid_i = 1'b0; bus1.xfer_tready_i = 1'b0;
    bus1.hnd_claim_i = '0; bus1.hnd_gnt_i = '0; bus1.hnd_done_i = '0;
    bus1.hnd_tvalid_i = '0; bus1.hnd_tlast_i = '0; bus1.hnd_tdata_i = '0;
    #1;
    check("rst_owner", 32'(bus.owner_o), 32'd0);
    check("rst_busy",  32'(bus.busy_o), 32'd0);
    check("rst_req",   32'(bus.hnd_req_o), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Handler 2 claims in the first CLAIM cycle.
    bus.xfer_req_i = 1'b1;
    tick();
    check("claim_busy", 32'(bus.busy_o), 32'd1);
    bus.hnd_claim_i = 3'b100;
    tick();
    #1;
    check("h2_owner", 32'(bus.owner_o), 32'd2);
    check("h2_req",   32'(bus.hnd_req_o), 32'b100);
    check("model_owner_h2", 32'(m_owner), 32'd2);
    bus.hnd_gnt_i = 3'b100;
    #1;
    check("h2_gnt_pass", 32'(bus.xfer_gnt_o), 32'd1);
    bus.hnd_gnt_i = 3'b001;
    bus.hnd_claim_i = 3'b001;
    #1;
    check("h0_gnt_block", 32'(bus.xfer_gnt_o), 32'd0);
    tick();
    #1;
    check("late_claim_ignored", 32'(bus.owner_o), 32'd2);
    idle_inputs();
    tick();
    check("h2_release", 32'(bus.busy_o), 32'd0);

    // Handlers 1 and 2 claim together; 18-byte descriptor from handler 1.
    foreach (desc[i]) desc[i] = 8'($urandom);
    acquire(3'b110);
    #1;
    check("tie_owner", 32'(bus.owner_o), 32'd1);
    got = 0; last_at = -1; t2_seen = 0;
    for (int cyc = 0; cyc < 200 && got < 18; cyc++) begin
      bus.hnd_tvalid_i = {1'b1, 1'b1, 1'b0};
      bus.hnd_tdata_i  = {8'($urandom), desc[got], 8'h00};
      bus.hnd_tlast_i  = {1'b1, (got == 17), 1'b0};
      bus.xfer_tready_i = 1'($urandom_range(0, 1));
      #1;
      if (bus.hnd_tready_o[2]) t2_seen++;
      if (bus.xfer_tvalid_o && bus.xfer_tready_i) begin
        rx[got] = bus.xfer_tdata_o;
        if (bus.xfer_tlast_o) last_at = got;
        got++;
      end
      tick();
    end
    check("desc_count", 32'(got), 32'd18);
    bad = 0;
    for (int i = 0; i < 18; i++) if (i < got && rx[i] !== desc[i]) bad++;
    check("desc_bytes", 32'(bad), 32'd0);
    check("desc_tlast", 32'(last_at), 32'd17);
    check("h2_tready_zero", 32'(t2_seen), 32'd0);
    idle_inputs();
    tick();

    // No claim: STALL on the fifth cycle after the request.
    bus.xfer_req_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      #1;
      check($sformatf("stall_c%0d", c), 32'(bus.xfer_stall_o), (c >= 5) ? 32'd1 : 32'd0);
    end
    bus.xfer_req_i = 1'b0;
    #1;
    check("stall_hold", 32'(bus.xfer_stall_o), 32'd1);
    tick();
    check("stall_clear", 32'(bus.xfer_stall_o), 32'd0);

    // Abort after byte 7 of a 64-byte IN stream, then immediate re-request.
    acquire(3'b001);
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 7; cyc++) begin
      bus.hnd_tvalid_i = 3'b001;
      bus.hnd_tdata_i  = {16'h0000, 8'(got)};
      bus.hnd_tlast_i  = '0;
      bus.xfer_tready_i = 1'b1;
      #1;
      if (bus.xfer_tvalid_o && bus.xfer_tready_i) got++;
      tick();
    end
    check("abort_bytes", 32'(got), 32'd7);
    bus.xfer_req_i = 1'b0;
    tick();
    #1;
    check("abort_req", 32'(bus.hnd_req_o), 32'd0);
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    idle_inputs();
    acquire(3'b010);
    #1;
    check("rearb_owner", 32'(bus.owner_o), 32'd1);
    check("rearb_req", 32'(bus.hnd_req_o), 32'b010);

    // OUT stage: 8 dvalid pulses reach only the owner.
    own_p = 0; other_p = 0;
    for (int c = 0; c < 16; c++) begin
      bus.xfer_dvalid_i = (c % 2 == 0);
      #1;
      if (bus.hnd_dvalid_o[1]) own_p++;
      if (bus.hnd_dvalid_o[0] || bus.hnd_dvalid_o[2]) other_p++;
      tick();
    end
    check("out_owner_pulses", 32'(own_p), 32'd8);
    check("out_other_pulses", 32'(other_p), 32'd0);
    idle_inputs();
    tick();

    // Request drop and claim in the same CLAIM cycle: abort wins.
    bus.xfer_req_i = 1'b1;
    tick();
    bus.xfer_req_i = 1'b0;
    bus.hnd_claim_i = 3'b001;
    tick();
    #1;
    check("abort_vs_claim_busy", 32'(bus.busy_o), 32'd0);
    check("abort_vs_claim_owner", 32'(bus.owner_o), 32'd1);
    idle_inputs();
    tick();

    // Async reset mid-stream in OWNED: outputs clear without a clock edge.
    acquire(3'b100);
    bus.hnd_tvalid_i = 3'b100; bus.hnd_tdata_i = {8'hA5, 16'h0000}; bus.hnd_tlast_i = 3'b100;
    bus.xfer_tready_i = 1'b1; bus.hnd_gnt_i = 3'b100; bus.xfer_dvalid_i = 1'b1;
    #1;
    check("pre_rst_tvalid", 32'(bus.xfer_tvalid_o), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_req",    32'(bus.hnd_req_o), 32'd0);
    check("arst_gnt",    32'(bus.xfer_gnt_o), 32'd0);
    check("arst_tvalid", 32'(bus.xfer_tvalid_o), 32'd0);
    check("arst_tdata",  32'(bus.xfer_tdata_o), 32'd0);
    check("arst_tready", 32'(bus.hnd_tready_o), 32'd0);
    check("arst_dvalid", 32'(bus.hnd_dvalid_o), 32'd0);
    check("arst_owner",  32'(bus.owner_o), 32'd0);
    check("arst_busy",   32'(bus.busy_o), 32'd0);
    idle_inputs();
    tick();
    reset = 1'b0;
    tick();

    // CLAIM_CYCLES=1 instance: one unclaimed CLAIM cycle stalls.
    bus1.xfer_req_i = 1'b1;
    tick();
    #1;
    check("cc1_claim_busy", 32'(bus1.busy_o), 32'd1);
    check("cc1_claim_stall", 32'(bus1.xfer_stall_o), 32'd0);
    tick();
    #1;
    check("cc1_stall", 32'(bus1.xfer_stall_o), 32'd1);
    bus1.xfer_req_i = 1'b0;
    tick();
    bus1.xfer_req_i = 1'b1;
    bus1.hnd_claim_i = 2'b10;
    tick();
    tick();
    #1;
    check("cc1_owner", 32'(bus1.owner_o), 32'd1);
    check("cc1_req", 32'(bus1.hnd_req_o), 32'b10);
    bus1.xfer_req_i = 1'b0;
    bus1.hnd_claim_i = '0;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2500; c++) begin
      if (bus.xfer_req_i) bus.xfer_req_i = ($urandom_range(0, 19) != 0);
      else                bus.xfer_req_i = ($urandom_range(0, 2) == 0);
      bus.hnd_claim_i   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      bus.hnd_gnt_i     = N'($urandom);
      bus.hnd_done_i    = N'($urandom);
      bus.hnd_tvalid_i  = N'($urandom);
      bus.hnd_tlast_i   = N'($urandom);
      bus.hnd_tdata_i   = (8*N)'($urandom);
      bus.xfer_dvalid_i = 1'($urandom);
      bus.xfer_tready_i = 1'($urandom);
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_ctl_mux.md
Name: usb_ctl_mux

Overview:
- Parametrised control-transfer router between the USB transfer engine's control port and up to N request handlers: standard-request block, vendor/class handlers, and user logic.
- Generalises the fixed two-way std/user split into a claim-based N-way arbiter with a latched owner, a claim timeout with STALL, and abort on request withdrawal.
- Sits between usb_xfer and the handler blocks inside the USB top level.

Parameters:
- NUM_HANDLERS, 2, number of handler channels (2..8); index 0 has highest priority.
- OWNER_BITS, 3, width of owner_o; must satisfy 2**OWNER_BITS >= NUM_HANDLERS.
- CLAIM_CYCLES, 4, cycles allowed for any handler to claim a SETUP before STALL (1..255).

Ports:
- clock  in  1  USB clock (60 MHz ULPI).
- reset  in  1  asynchronous, active-high reset.
- xfer_req_i  in  1  control transfer pending from usb_xfer; level, held until completion or abort.
- xfer_gnt_o  out  1  accept back to usb_xfer.
- xfer_done_o  out  1  status stage done.
- xfer_stall_o  out  1  no handler claimed; usb_xfer returns STALL.
- xfer_dvalid_i  in  1  OUT data-stage byte valid.
- xfer_tvalid_o, xfer_tlast_o  out  1  IN data stream to usb_xfer.
- xfer_tready_i  in  1  IN data stream ready.
- xfer_tdata_o  out  8  IN data byte.
- hnd_claim_i  in  N  per-handler combinational decode of the current SETUP fields.
- hnd_req_o  out  N  one-hot request to the owner.
- hnd_gnt_i, hnd_done_i  in  N  per-handler accept/done.
- hnd_dvalid_o  out  N  OUT byte valid, owner only.
- hnd_tvalid_i, hnd_tlast_i  in  N  per-handler IN stream.
- hnd_tready_o  out  N  ready, owner only.
- hnd_tdata_i  in  8*N  packed IN bytes; handler k uses bits [8k+7:8k].
- owner_o  out  OWNER_BITS  latched owner index.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, owner 0, counter 0. Reset applies mid-transfer with no drain.
- States: IDLE, CLAIM, OWNED, STALL.
- IDLE:
  - xfer_req_i=1 -> CLAIM, counter cleared.
  - hnd_req_o=0, xfer_gnt_o=0.
- CLAIM:
  - Any hnd_claim_i bit set -> latch lowest set index into owner, go OWNED next cycle.
  - Otherwise counter increments; when counter == CLAIM_CYCLES-1 with no claim -> STALL.
  - xfer_req_i falls -> IDLE.
- OWNED:
  - hnd_req_o = one-hot(owner).
  - xfer_gnt_o = hnd_gnt_i[owner]; xfer_done_o = hnd_done_i[owner].
  - hnd_dvalid_o[owner] = xfer_dvalid_i; all other bits 0.
  - IN path: xfer_tvalid/tlast/tdata from the owner; hnd_tready_o[owner] = xfer_tready_i; non-owners see tready=0.
  - xfer_req_i falls (completion or host abort/new SETUP) -> IDLE on the next edge; hnd_req_o drops in that cycle.
- STALL:
  - xfer_stall_o=1, xfer_gnt_o=0.
  - Hold until xfer_req_i=0, then IDLE.
- Timing:
  - Request-to-owner latency: 1 cycle after the first claim.
  - With CLAIM_CYCLES=1, a request with no claim in its first CLAIM cycle stalls.
- Simultaneous claims: lowest index wins; later claim changes in OWNED are ignored.
- xfer_req_i falling in the same cycle as a claim: abort wins, return to IDLE.
- xfer_req_i re-asserting in the IDLE cycle right after abort starts a new CLAIM (no dead cycle required).
- Owner index >= NUM_HANDLERS is unreachable.

Optional Feature:
- Macro: USB_CTL_MUX_SKID_EN.
- Defined:
  - 2-entry skid buffer on the muxed IN stream; xfer_t* outputs are registered.
  - Adds 1 cycle IN latency; hnd_tready_o[owner] is driven by buffer not-full.
  - Buffer flushes on the transition to IDLE or STALL.
- Undefined: IN path is purely combinational, as described under Behaviour.

Test Plan:
- Handler 2 claims in the first CLAIM cycle (N=3) -> owner_o=2 and hnd_req_o=3'b100 next cycle; hnd_gnt_i[2] pulse appears on xfer_gnt_o the same cycle.
- Handlers 1 and 2 claim together -> owner_o=1; handler 2 sees tready=0 throughout; an 18-byte descriptor from handler 1 arrives intact with tlast on byte 18.
- No claim, CLAIM_CYCLES=4 -> xfer_stall_o=1 on cycle 5 after the request; it clears one cycle after xfer_req_i drops.
- xfer_req_i drops mid IN-stream after byte 7 of 64 -> hnd_req_o=0 next cycle, busy_o=0; a new request then re-arbitrates cleanly.
- OUT stage, 8 bytes with xfer_dvalid_i -> hnd_dvalid_o pulses only on the owner bit, 8 pulses.
- Async reset asserted in OWNED mid-stream -> all outputs 0 immediately, no clock edge required.
